// File: rtl/symbols_counter_pkg.sv
// Shared types and defaults for the symbols counter host side.
// Used by the job driver and the start/ready transaction engine.
package symbols_counter_pkg;

    localparam int S_WIDTH_DEF   = 8;
    localparam int MAX_ALPHA_DEF = 255;
    localparam int START_GAP_DEF = 2;
    localparam int TIMEOUT_DEF   = 1024;

    localparam logic MODE_ALPHA = 1'b0;
    localparam logic MODE_TEXT  = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLR,
        ST_FETCH,
        ST_XFER,
        ST_GAP,
        ST_READ,
        ST_EMIT,
        ST_REWIND,
        ST_DONE
    } state_t;

    // What the transaction in flight was issued for
    typedef enum logic [1:0] {
        K_SYM,
        K_READ,
        K_REWIND
    } kind_t;

    typedef enum logic [1:0] {
        XP_IDLE,
        XP_WAIT,
        XP_GAP
    } xphase_t;

endpackage

// File: rtl/ctr_xact.sv
// Start/ready four-phase engine: holds start until ready rises,
// then keeps start low for a gap; gives up after a timeout.
module ctr_xact
    import symbols_counter_pkg::*;
#(
    parameter int START_GAP      = START_GAP_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic clock,
    input  logic reset_n,
    input  logic launch,
    input  logic ctr_ready_in,
    output logic ctr_start,
    output logic ack,
    output logic gap_done,
    output logic timeout
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int GW = $clog2(START_GAP) + 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] G_LAST = GW'(START_GAP - 1);

    xphase_t       phase;
    logic          ready_q;
    logic [TW-1:0] timer;
    logic [GW-1:0] gap_cnt;

    // Only a fresh 0->1 ready edge completes; a stale high is ignored
    assign ack      = (phase == XP_WAIT) && ctr_ready_in && !ready_q;
    assign timeout  = (phase == XP_WAIT) && !ack && (timer == T_LAST);
    assign gap_done = (phase == XP_GAP) && (gap_cnt == G_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase     <= XP_IDLE;
            ready_q   <= 1'b0;
            timer     <= '0;
            gap_cnt   <= '0;
            ctr_start <= 1'b0;
        end else begin
            ready_q <= ctr_ready_in;
            unique case (phase)
                XP_IDLE: begin
                    if (launch) begin
                        ctr_start <= 1'b1;
                        timer     <= '0;
                        phase     <= XP_WAIT;
                    end
                end
                XP_WAIT: begin
                    unique case (1'b1)
                        ack: begin
                            ctr_start <= 1'b0;
                            gap_cnt   <= '0;
                            phase     <= XP_GAP;
                        end
                        timeout: begin
                            ctr_start <= 1'b0;
                            phase     <= XP_IDLE;
                        end
                        default: timer <= timer + TW'(1);
                    endcase
                end
                XP_GAP: begin
                    if (gap_done) begin
                        phase <= XP_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: phase <= XP_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/symbols_counter_driver.sv
// Job-level initiator for the symbols counter: loads alphabet and text,
// then reads back one occurrence count per alphabet entry as a stream.
module symbols_counter_driver
    import symbols_counter_pkg::*;
#(
    parameter int S_WIDTH        = S_WIDTH_DEF,
    parameter int MAX_ALPHA      = MAX_ALPHA_DEF,
    parameter int START_GAP      = START_GAP_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [S_WIDTH-1:0] in_data,
    input  logic               in_is_text,
    input  logic               in_last,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [S_WIDTH-1:0] res_symbol,
    output logic [7:0]         res_count,
    output logic               res_last,
    output logic               ctr_reset,
    output logic               ctr_start,
    output logic               ctr_mode,
    output logic               ctr_end_flag,
    output logic [S_WIDTH-1:0] ctr_symbol,
    input  logic               ctr_ready_in,
    input  logic [7:0]         ctr_count_in,
    input  logic [S_WIDTH-1:0] ctr_symbol_out,
    output logic               busy,
    output logic               done,
    output logic               err_order,
    output logic               err_overflow,
    output logic               err_timeout
);

    localparam logic [7:0] AMAX = 8'(MAX_ALPHA);

    state_t     state;
    kind_t      kind;
    logic [7:0] alpha_cnt;
    logic [7:0] rd_cnt;
    logic       text_seen;
    logic       last_q;

    logic launch;
    logic ack;
    logic gap_done;
    logic xact_to;
    logic take;
    logic drop_order;
    logic drop_over;
    logic drop;

    assign take       = (state == ST_FETCH) && in_valid && in_ready;
    assign drop_order = !in_is_text && text_seen;
    assign drop_over  = !in_is_text && !text_seen && (alpha_cnt == AMAX);
    assign drop       = drop_order || drop_over;

    assign launch = (take && !drop)
                 || ((state == ST_READ) && (rd_cnt != alpha_cnt))
                 || (state == ST_REWIND);

    assign busy = (state != ST_IDLE);

    ctr_xact #(
        .START_GAP      (START_GAP),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_xact (
        .clock        (clock),
        .reset_n      (reset_n),
        .launch       (launch),
        .ctr_ready_in (ctr_ready_in),
        .ctr_start    (ctr_start),
        .ack          (ack),
        .gap_done     (gap_done),
        .timeout      (xact_to)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            kind         <= K_SYM;
            in_ready     <= 1'b0;
            res_valid    <= 1'b0;
            res_symbol   <= '0;
            res_count    <= '0;
            res_last     <= 1'b0;
            ctr_reset    <= 1'b0;
            ctr_mode     <= MODE_ALPHA;
            ctr_end_flag <= 1'b0;
            ctr_symbol   <= '0;
            done         <= 1'b0;
            err_order    <= 1'b0;
            err_overflow <= 1'b0;
            err_timeout  <= 1'b0;
            alpha_cnt    <= '0;
            rd_cnt       <= '0;
            text_seen    <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            ctr_reset <= 1'b0;
            done      <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        ctr_reset <= 1'b1;
                        state     <= ST_CLR;
                    end
                end
                ST_CLR: begin
                    alpha_cnt <= '0;
                    rd_cnt    <= '0;
                    text_seen <= 1'b0;
                    last_q    <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (take) begin
                        last_q       <= in_last;
                        err_order    <= err_order | drop_order;
                        err_overflow <= err_overflow | drop_over;
                        if (!drop) begin
                            in_ready     <= 1'b0;
                            ctr_symbol   <= in_data;
                            ctr_mode     <= in_is_text ? MODE_TEXT : MODE_ALPHA;
                            ctr_end_flag <= 1'b0;
                            kind         <= K_SYM;
                            state        <= ST_XFER;
                            if (in_is_text) begin
                                text_seen <= 1'b1;
                            end else begin
                                alpha_cnt <= alpha_cnt + 8'd1;
                            end
                        end else if (in_last) begin
                            in_ready <= 1'b0;
                            state    <= ST_READ;
                        end
                    end
                end
                ST_XFER: begin
                    unique case (1'b1)
                        ack: begin
                            if (kind == K_READ) begin
                                res_symbol <= ctr_symbol_out;
                                res_count  <= ctr_count_in;
                                res_last   <= (rd_cnt == alpha_cnt);
                            end
                            state <= ST_GAP;
                        end
                        xact_to: begin
                            err_timeout <= 1'b1;
                            ctr_reset   <= 1'b1;
                            done        <= 1'b1;
                            state       <= ST_DONE;
                        end
                        default: ;
                    endcase
                end
                ST_GAP: begin
                    if (gap_done) begin
                        unique case (kind)
                            K_READ: begin
                                res_valid <= 1'b1;
                                state     <= ST_EMIT;
                            end
                            K_REWIND: begin
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end
                            default: begin
                                if (last_q) begin
                                    state <= ST_READ;
                                end else begin
                                    in_ready <= 1'b1;
                                    state    <= ST_FETCH;
                                end
                            end
                        endcase
                    end
                end
                ST_READ: begin
                    if (rd_cnt == alpha_cnt) begin
                        state <= ST_REWIND;
                    end else begin
                        ctr_end_flag <= 1'b1;
                        ctr_mode     <= MODE_TEXT;
                        ctr_symbol   <= '0;
                        rd_cnt       <= rd_cnt + 8'd1;
                        kind         <= K_READ;
                        state        <= ST_XFER;
                    end
                end
                ST_EMIT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        res_last  <= 1'b0;
                        state     <= ST_READ;
                    end
                end
                // Readout wraps the counter's pointer back to entry 0
                ST_REWIND: begin
                    ctr_end_flag <= 1'b1;
                    ctr_mode     <= MODE_TEXT;
                    ctr_symbol   <= '0;
                    kind         <= K_REWIND;
                    state        <= ST_XFER;
                end
                ST_DONE: begin
                    ctr_end_flag <= 1'b0;
                    ctr_mode     <= MODE_ALPHA;
                    ctr_symbol   <= '0;
                    in_ready     <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_symbols_counter_driver.sv
// Directed bench for symbols_counter_driver with a behavioural counter
// and a result scoreboard.
module tb_symbols_counter_driver;

    localparam int TMO   = 1024;
    localparam int LIMIT = 20000;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_is_text;
    logic       in_last;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_symbol;
    logic [7:0] res_count;
    logic       res_last;
    logic       ctr_reset;
    logic       ctr_start;
    logic       ctr_mode;
    logic       ctr_end_flag;
    logic [7:0] ctr_symbol;
    logic       ctr_ready_in = 1'b0;
    logic [7:0] ctr_count_in = 8'd0;
    logic [7:0] ctr_symbol_out = 8'd0;
    logic       busy;
    logic       done;
    logic       err_order;
    logic       err_overflow;
    logic       err_timeout;

    typedef struct {
        logic [7:0] sym;
        logic [7:0] cnt;
        logic       last;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   xfers = 0;
    logic start_prev = 1'b0;

    logic [7:0] job_a [256];
    logic [7:0] job_t [16];
    int         na;
    int         nt;

    always #5 clock = ~clock;

    symbols_counter_driver #(
        .S_WIDTH        (8),
        .MAX_ALPHA      (255),
        .START_GAP      (2),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_is_text     (in_is_text),
        .in_last        (in_last),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_symbol     (res_symbol),
        .res_count      (res_count),
        .res_last       (res_last),
        .ctr_reset      (ctr_reset),
        .ctr_start      (ctr_start),
        .ctr_mode       (ctr_mode),
        .ctr_end_flag   (ctr_end_flag),
        .ctr_symbol     (ctr_symbol),
        .ctr_ready_in   (ctr_ready_in),
        .ctr_count_in   (ctr_count_in),
        .ctr_symbol_out (ctr_symbol_out),
        .busy           (busy),
        .done           (done),
        .err_order      (err_order),
        .err_overflow   (err_overflow),
        .err_timeout    (err_timeout)
    );

    // Behavioural symbols counter: 3-cycle answer, pointer wraps at length
    logic [7:0] m_alpha [256];
    logic [7:0] m_cnt [256];
    logic [8:0] m_len = 9'd0;
    logic [7:0] m_rp = 8'd0;
    logic [1:0] m_dly = 2'd0;
    logic       m_dead = 1'b0;

    always @(posedge clock) begin
        if (ctr_reset) begin
            m_len        <= 9'd0;
            m_rp         <= 8'd0;
            m_dly        <= 2'd0;
            ctr_ready_in <= 1'b0;
            for (int i = 0; i < 256; i++) m_cnt[i] <= 8'd0;
        end else if (m_dead) begin
            ctr_ready_in <= 1'b0;
            m_dly        <= 2'd0;
        end else if (ctr_start && !ctr_ready_in) begin
            if (m_dly < 2'd2) begin
                m_dly <= m_dly + 2'd1;
            end else begin
                m_dly        <= 2'd0;
                ctr_ready_in <= 1'b1;
                if (ctr_end_flag) begin
                    if ({1'b0, m_rp} >= m_len) begin
                        m_rp           <= 8'd0;
                        ctr_count_in   <= 8'd0;
                        ctr_symbol_out <= 8'd0;
                    end else begin
                        ctr_count_in   <= m_cnt[m_rp];
                        ctr_symbol_out <= m_alpha[m_rp];
                        m_rp           <= m_rp + 8'd1;
                    end
                end else if (!ctr_mode) begin
                    if (m_len < 9'd256) begin
                        m_alpha[m_len[7:0]] <= ctr_symbol;
                        m_len               <= m_len + 9'd1;
                    end
                end else begin
                    for (int i = 0; i < 256; i++) begin
                        if (9'(i) < m_len && m_alpha[i[7:0]] == ctr_symbol)
                            m_cnt[i[7:0]] <= m_cnt[i[7:0]] + 8'd1;
                    end
                end
            end
        end else if (!ctr_start) begin
            ctr_ready_in <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({in_ready, res_valid, res_symbol, res_count, res_last,
                    ctr_reset, ctr_start, ctr_mode, ctr_end_flag,
                    ctr_symbol, busy, done,
                    err_order, err_overflow, err_timeout});
    endfunction

    // Transaction counter (rising edges of ctr_start)
    initial forever begin
        @(negedge clock);
        if (ctr_start && !start_prev) xfers++;
        start_prev = ctr_start;
    end

    // Result monitor: handshake happens at the following rising edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset_n && res_valid && res_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_result: observed sym %0h cnt %0d, expected none",
                           res_symbol, res_count);
                end else begin
                    e = sb_q.pop_front();
                    check("res_symbol", 64'(res_symbol), 64'(e.sym));
                    check("res_count", 64'(res_count), 64'(e.cnt));
                    check("res_last", 64'(res_last), 64'(e.last));
                end
            end
        end
    end

    task automatic push_expected();
        int   n;
        exp_t e;
        n = (na > 255) ? 255 : na;
        for (int i = 0; i < n; i++) begin
            e.sym  = job_a[i];
            e.cnt  = 8'd0;
            e.last = (i == n - 1);
            for (int j = 0; j < nt; j++)
                if (job_t[j] == job_a[i]) e.cnt = e.cnt + 8'd1;
            sb_q.push_back(e);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic t, input logic l);
        int   n;
        logic ok;
        n  = 0;
        ok = 1'b0;
        in_valid   = 1'b1;
        in_data    = d;
        in_is_text = t;
        in_last    = l;
        while (!ok && n < LIMIT) begin
            @(negedge clock);
            n++;
            ok = (in_ready === 1'b1);
        end
        if (!ok) begin
            checks++;
            errors++;
            $error("FAIL in_handshake: in_ready low for %0d cycles, expected 1", n);
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_job();
        push_expected();
        for (int i = 0; i < na; i++)
            send(job_a[i], 1'b0, (nt == 0) && (i == na - 1));
        for (int i = 0; i < nt; i++)
            send(job_t[i], 1'b1, i == nt - 1);
    endtask

    task automatic wait_done(input string tag, output int cyc);
        logic hit;
        cyc = 0;
        hit = 1'b0;
        while (!hit && cyc < LIMIT) begin
            @(negedge clock);
            cyc++;
            hit = (done === 1'b1);
        end
        if (!hit) begin
            checks++;
            errors++;
            $error("FAIL %s_done: no done pulse in %0d cycles, expected one", tag, cyc);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int cyc;
        int base;
        int wait_n;

        reset_n    = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'd0;
        in_is_text = 1'b0;
        in_last    = 1'b0;
        res_ready  = 1'b1;

        repeat (2) @(negedge clock);
        check("reset_outputs", outs(), 64'd0);
        do_reset();

        // Job 1: {A,B,C} over "ABACA", first result stalled 20 cycles
        na = 3;
        job_a[0] = 8'h41; job_a[1] = 8'h42; job_a[2] = 8'h43;
        nt = 5;
        job_t[0] = 8'h41; job_t[1] = 8'h42; job_t[2] = 8'h41;
        job_t[3] = 8'h43; job_t[4] = 8'h41;
        res_ready = 1'b0;
        base = xfers;
        run_job();
        wait_n = 0;
        while (res_valid !== 1'b1 && wait_n < LIMIT) begin
            @(negedge clock);
            wait_n++;
        end
        check("first_res_valid", 64'(res_valid), 64'd1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            check("stall_hold",
                  64'({res_valid, res_symbol, res_count, res_last}),
                  64'({1'b1, sb_q[0].sym, sb_q[0].cnt, sb_q[0].last}));
        end
        @(posedge clock);
        #1;
        res_ready = 1'b1;
        wait_done("job1", cyc);
        check("job1_xfers", 64'(xfers - base), 64'(3 + 5 + 3 + 1));
        check("job1_sb_empty", 64'(sb_q.size()), 64'd0);
        check("job1_errs", 64'({err_order, err_overflow, err_timeout}), 64'd0);
        @(negedge clock);
        check("job1_idle", 64'({busy, done}), 64'd0);

        // Zero-alphabet job: only the rewind transaction follows the text
        na = 0;
        nt = 1;
        job_t[0] = 8'h41;
        base = xfers;
        run_job();
        wait_done("zero", cyc);
        check("zero_xfers", 64'(xfers - base), 64'd2);
        check("zero_sb_empty", 64'(sb_q.size()), 64'd0);

        // Alphabet symbol after text is dropped
        na = 2;
        job_a[0] = 8'h41; job_a[1] = 8'h42;
        nt = 3;
        job_t[0] = 8'h41; job_t[1] = 8'h42; job_t[2] = 8'h41;
        push_expected();
        base = xfers;
        send(8'h41, 1'b0, 1'b0);
        send(8'h42, 1'b0, 1'b0);
        send(8'h41, 1'b1, 1'b0);
        send(8'h42, 1'b1, 1'b0);
        send(8'h43, 1'b0, 1'b0);
        send(8'h41, 1'b1, 1'b1);
        wait_done("order", cyc);
        check("order_xfers", 64'(xfers - base), 64'(2 + 3 + 2 + 1));
        check("order_flags", 64'({err_order, err_overflow}), 64'b10);
        check("order_sb_empty", 64'(sb_q.size()), 64'd0);

        // 256 alphabet symbols: the last one overflows and is dropped
        na = 256;
        for (int i = 0; i < 256; i++) job_a[i] = 8'(i);
        nt = 3;
        job_t[0] = 8'd5; job_t[1] = 8'd5; job_t[2] = 8'd255;
        base = xfers;
        run_job();
        wait_done("ovf", cyc);
        check("ovf_flag", 64'(err_overflow), 64'd1);
        check("ovf_xfers", 64'(xfers - base), 64'(255 + 3 + 255 + 1));
        check("ovf_sb_empty", 64'(sb_q.size()), 64'd0);

        // Counter never answers
        m_dead = 1'b1;
        send(8'h41, 1'b0, 1'b1);
        wait_done("tmo", cyc);
        check("tmo_cycles", 64'(cyc), 64'(TMO + 1));
        check("tmo_pulse", 64'({ctr_reset, err_timeout, res_valid}), 64'b110);
        m_dead = 1'b0;
        @(negedge clock);
        check("tmo_idle", 64'({busy, done, ctr_reset}), 64'd0);

        do_reset();
        check("errs_cleared", 64'({err_order, err_overflow, err_timeout}), 64'd0);

        // Back-to-back jobs
        na = 1;
        job_a[0] = 8'h58;
        nt = 2;
        job_t[0] = 8'h58; job_t[1] = 8'h58;
        run_job();
        wait_done("b2b1", cyc);
        nt = 1;
        run_job();
        wait_done("b2b2", cyc);
        check("b2b_sb_empty", 64'(sb_q.size()), 64'd0);

        // Reset in the middle of a transaction
        send(8'h41, 1'b0, 1'b0);
        @(negedge clock);
        check("mid_xfer_start", 64'({ctr_start, busy}), 64'b11);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_reset_outputs", outs(), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        na = 2;
        job_a[0] = 8'h41; job_a[1] = 8'h42;
        nt = 3;
        job_t[0] = 8'h42; job_t[1] = 8'h42; job_t[2] = 8'h41;
        run_job();
        wait_done("after_reset", cyc);
        check("after_reset_sb_empty", 64'(sb_q.size()), 64'd0);

        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
